// File: rtl/mem_stage.sv
// RV32I memory stage and MEM/WB pipeline register: drives the data bus, aligns loads, stalls on wait states.
// Optional access timeout is enabled with `define MEM_TIMEOUT_EN.
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic        MemWriteM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] ALUoutM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] inc_PCM,
   input  logic [4:0]  RdM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        stall_M,
   output logic        mem_err,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [31:0] ALUoutW,
   output logic [31:0] ReadDataW,
   output logic [31:0] inc_PCW,
   output logic [4:0]  RdW
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

   state_e      state_q;
   logic        load_s;
   logic        memop_s;
   logic        timeout_s;
   logic        stall_s;
   logic [31:0] rdata_s;
   logic [31:0] ld_data_s;
   logic [31:0] wdata_s;
   logic [3:0]  wstrb_s;

   logic        regwrite_w_q;
   logic [1:0]  resultsrc_w_q;
   logic [31:0] aluout_w_q;
   logic [31:0] readdata_w_q;
   logic [31:0] inc_pc_w_q;
   logic [4:0]  rd_w_q;

   // Select, align and extend the load lane from the bus word.
   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
      logic [31:0] shifted;
      logic [15:0] half;
      shifted = word >> {off, 3'b000};
      half    = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  load_extract = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_extract = {24'h000000, shifted[7:0]};
         3'b001:  load_extract = {{16{half[15]}}, half};
         3'b101:  load_extract = {16'h0000, half};
         default: load_extract = word;
      endcase
   endfunction

   assign load_s    = (ResultSrcM == 2'b01);
   assign memop_s   = load_s | MemWriteM;
   assign stall_s   = memop_s & ~mem_ready & ~timeout_s;
   assign stall_M   = stall_s;
   assign mem_req   = memop_s & rst_n;
   assign mem_we    = MemWriteM;
   assign mem_addr  = {ALUoutM[31:2], 2'b00};
   assign mem_wdata = wdata_s;
   assign mem_wstrb = wstrb_s;

   // Store lane replication and byte strobes.
   always_comb begin
      wdata_s = WriteDataM;
      wstrb_s = 4'b1111;
      case (funct3M)
         3'b000: begin
            wdata_s = {4{WriteDataM[7:0]}};
            wstrb_s = 4'b0001 << ALUoutM[1:0];
         end
         3'b001: begin
            wdata_s = {2{WriteDataM[15:0]}};
            wstrb_s = ALUoutM[1] ? 4'b1100 : 4'b0011;
         end
         3'b010: begin
            wdata_s = WriteDataM;
            wstrb_s = 4'b1111;
         end
         default: begin
            wdata_s = WriteDataM;
            wstrb_s = 4'b1111;
         end
      endcase
   end

   // An abandoned access completes with a zero read word.
   assign rdata_s   = timeout_s ? 32'h0000_0000 : mem_rdata;
   assign ld_data_s = load_s ? load_extract(funct3M, ALUoutM[1:0], rdata_s) : 32'h0000_0000;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (($clog2(TIMEOUT_CYCLES) + 1) > 5) ? ($clog2(TIMEOUT_CYCLES) + 1) : 5;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   assign timeout_s = (state_q == WAIT) && (cnt_q == CNT_LAST) && !mem_ready;
   assign mem_err   = err_q;

   // Wait-cycle counter and one-cycle error pulse after a timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
         err_q <= 1'b0;
      end else begin
         err_q <= timeout_s;
         if ((state_q == WAIT) && !mem_ready && !timeout_s) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_q <= {CNT_W{1'b0}};
         end
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign timeout_s = 1'b0;
   assign mem_err   = 1'b0;
`endif

   // Handshake FSM: WAIT covers every cycle the slave has not yet answered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (memop_s && !mem_ready) state_q <= WAIT;
               else                       state_q <= IDLE;
            end
            WAIT: begin
               if (mem_ready || timeout_s) state_q <= IDLE;
               else                        state_q <= WAIT;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // MEM/WB register; a stall inserts a bubble by clearing the write enable and Rd.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regwrite_w_q  <= 1'b0;
         resultsrc_w_q <= 2'b00;
         aluout_w_q    <= 32'h0000_0000;
         readdata_w_q  <= 32'h0000_0000;
         inc_pc_w_q    <= 32'h0000_0000;
         rd_w_q        <= 5'd0;
      end else if (!stall_s) begin
         regwrite_w_q  <= RegWriteM;
         resultsrc_w_q <= ResultSrcM;
         aluout_w_q    <= ALUoutM;
         readdata_w_q  <= ld_data_s;
         inc_pc_w_q    <= inc_PCM;
         rd_w_q        <= RdM;
      end else begin
         regwrite_w_q  <= 1'b0;
         rd_w_q        <= 5'd0;
      end
   end

   assign RegWriteW  = regwrite_w_q;
   assign ResultSrcW = resultsrc_w_q;
   assign ALUoutW    = aluout_w_q;
   assign ReadDataW  = readdata_w_q;
   assign inc_PCW    = inc_pc_w_q;
   assign RdW        = rd_w_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; the timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        RegWriteM;
   logic [1:0]  ResultSrcM;
   logic        MemWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUoutM;
   logic [31:0] WriteDataM;
   logic [31:0] inc_PCM;
   logic [4:0]  RdM;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        stall_M;
   logic        mem_err;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUoutW;
   logic [31:0] ReadDataW;
   logic [31:0] inc_PCW;
   logic [4:0]  RdW;

   int tests = 0;
   int fails = 0;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
      .MemWriteM(MemWriteM), .funct3M(funct3M), .ALUoutM(ALUoutM), .WriteDataM(WriteDataM),
      .inc_PCM(inc_PCM), .RdM(RdM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .stall_M(stall_M), .mem_err(mem_err), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
      .ALUoutW(ALUoutW), .ReadDataW(ReadDataW), .inc_PCW(inc_PCW), .RdW(RdW)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_w_zero(input string tag);
      check32({tag, " RegWriteW"},  32'(RegWriteW),  32'h0);
      check32({tag, " ResultSrcW"}, 32'(ResultSrcW), 32'h0);
      check32({tag, " ALUoutW"},    ALUoutW,         32'h0);
      check32({tag, " ReadDataW"},  ReadDataW,       32'h0);
      check32({tag, " inc_PCW"},    inc_PCW,         32'h0);
      check32({tag, " RdW"},        32'(RdW),        32'h0);
   endtask

   task automatic set_op(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
      RegWriteM  = rw;
      ResultSrcM = rs;
      MemWriteM  = mw;
      funct3M    = f3;
      ALUoutM    = alu;
      WriteDataM = wd;
      RdM        = rd;
      inc_PCM    = alu + 32'h0000_1000;
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      set_op(1'b0, 2'b01, 1'b0, 3'b010, 32'h0, 32'h0, 5'd0);
      #2;
      check32("reset mem_req", 32'(mem_req), 32'h0);
      check32("reset mem_err", 32'(mem_err), 32'h0);
      check_w_zero("reset");
      #10;
      rst_n = 1'b1;

      // ALU passthrough
      set_op(1'b1, 2'b00, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
      #1;
      check32("alu mem_req", 32'(mem_req), 32'h0);
      check32("alu stall", 32'(stall_M), 32'h0);
      tick();
      check32("alu ALUoutW", ALUoutW, 32'h0000_1234);
      check32("alu RdW", 32'(RdW), 32'd5);
      check32("alu RegWriteW", 32'(RegWriteW), 32'h1);
      check32("alu inc_PCW", inc_PCW, 32'h0000_2234);
      check32("alu ReadDataW", ReadDataW, 32'h0);

      // LB / LBU / LH / LHU, zero-wait
      set_op(1'b1, 2'b01, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd6);
      mem_ready = 1'b1;
      mem_rdata = 32'h80FF_0000;
      #1;
      check32("lb mem_req", 32'(mem_req), 32'h1);
      check32("lb mem_we", 32'(mem_we), 32'h0);
      check32("lb mem_addr", mem_addr, 32'h0000_0100);
      check32("lb stall", 32'(stall_M), 32'h0);
      tick();
      check32("lb ReadDataW", ReadDataW, 32'hFFFF_FF80);
      check32("lb ResultSrcW", 32'(ResultSrcW), 32'h1);
      check32("lb RdW", 32'(RdW), 32'd6);
      funct3M = 3'b100;
      tick();
      check32("lbu ReadDataW", ReadDataW, 32'h0000_0080);
      set_op(1'b1, 2'b01, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd7);
      tick();
      check32("lh hi ReadDataW", ReadDataW, 32'hFFFF_80FF);
      mem_rdata = 32'h1234_8765;
      set_op(1'b1, 2'b01, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 5'd7);
      tick();
      check32("lhu lo ReadDataW", ReadDataW, 32'h0000_8765);

      // Stores
      set_op(1'b0, 2'b00, 1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 5'd0);
      #1;
      check32("sh wstrb", 32'(mem_wstrb), 32'hC);
      check32("sh wdata", mem_wdata, 32'hBEEF_BEEF);
      check32("sh we", 32'(mem_we), 32'h1);
      check32("sh addr", mem_addr, 32'h0000_0020);
      tick();
      check32("sh ReadDataW", ReadDataW, 32'h0);
      check32("sh RegWriteW", 32'(RegWriteW), 32'h0);
      set_op(1'b0, 2'b00, 1'b1, 3'b000, 32'h0000_0046, 32'h0000_00A5, 5'd0);
      #1;
      check32("sb wstrb", 32'(mem_wstrb), 32'h4);
      check32("sb wdata", mem_wdata, 32'hA5A5_A5A5);
      set_op(1'b0, 2'b00, 1'b1, 3'b010, 32'h0000_0030, 32'h1357_9BDF, 5'd0);
      #1;
      check32("sw wstrb", 32'(mem_wstrb), 32'hF);
      check32("sw wdata", mem_wdata, 32'h1357_9BDF);
      tick();
      check32("sw ALUoutW", ALUoutW, 32'h0000_0030);

      // LW with three wait states
      set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd9);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check32("wait stall", 32'(stall_M), 32'h1);
         check32("wait mem_req", 32'(mem_req), 32'h1);
         check32("wait mem_addr", mem_addr, 32'h0000_0200);
         check32("wait mem_we", 32'(mem_we), 32'h0);
         tick();
         check32("wait RegWriteW bubble", 32'(RegWriteW), 32'h0);
         check32("wait RdW bubble", 32'(RdW), 32'h0);
         check32("wait ALUoutW hold", ALUoutW, 32'h0000_0030);
      end
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      #1;
      check32("wait done stall", 32'(stall_M), 32'h0);
      tick();
      check32("wait ReadDataW", ReadDataW, 32'hCAFE_F00D);
      check32("wait RegWriteW", 32'(RegWriteW), 32'h1);
      check32("wait RdW", 32'(RdW), 32'd9);
      check32("wait ALUoutW", ALUoutW, 32'h0000_0200);
      check32("wait mem_err", 32'(mem_err), 32'h0);

      // Reset during WAIT
      set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd4);
      mem_ready = 1'b0;
      tick();
      check32("rstwait stall", 32'(stall_M), 32'h1);
      rst_n = 1'b0;
      #1;
      check32("rstwait mem_req", 32'(mem_req), 32'h0);
      check_w_zero("rstwait");
      set_op(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
      #1;
      rst_n = 1'b1;

      // Zero-wait load straight after reset release
      set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 5'd3);
      mem_ready = 1'b1;
      mem_rdata = 32'h1122_3344;
      #1;
      check32("post-rst stall", 32'(stall_M), 32'h0);
      tick();
      check32("post-rst ReadDataW", ReadDataW, 32'h1122_3344);
      check32("post-rst RdW", 32'(RdW), 32'd3);

      // mem_ready without a request is ignored
      set_op(1'b1, 2'b00, 1'b0, 3'b000, 32'h0000_0777, 32'h0, 5'd8);
      #1;
      check32("idle-ready mem_req", 32'(mem_req), 32'h0);
      check32("idle-ready stall", 32'(stall_M), 32'h0);
      tick();
      check32("idle-ready ReadDataW", ReadDataW, 32'h0);
      check32("idle-ready ALUoutW", ALUoutW, 32'h0000_0777);

`ifdef MEM_TIMEOUT_EN
      // Timeout with TIMEOUT_CYCLES=4
      set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd11);
      mem_ready = 1'b0;
      mem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         #1;
         check32("to stall", 32'(stall_M), 32'h1);
         tick();
         check32("to mem_err low", 32'(mem_err), 32'h0);
      end
      #1;
      check32("to stall drop", 32'(stall_M), 32'h0);
      tick();
      check32("to ReadDataW", ReadDataW, 32'h0);
      check32("to RegWriteW", 32'(RegWriteW), 32'h1);
      check32("to mem_err pulse", 32'(mem_err), 32'h1);
      set_op(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
      tick();
      check32("to mem_err end", 32'(mem_err), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
